button_conditioner: RTL and testbench

- Consumer end of the clock-divider tick strobes: takes one raw push-button input plus the 25 ms debounce tick and the 1 s tick, all in the 100 MHz `clk` domain.
- Synchronises and debounces the button.
- Emits single-cycle press, release, long-press and auto-repeat event pulses to the stopwatch/display control logic.
- Sits between board buttons and the control FSMs. One instance per button.

---
 rtl/btn_pkg.sv | 8 +
 rtl/tick_debouncer.sv | 45 ++++
 rtl/button_conditioner.sv | 105 ++++++++++
 tb/tb_button_conditioner.sv | 133 +++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: state encoding and default parameter values shared by button_conditioner and tick_debouncer.
//   Contents: btn_state_t (RELEASED/PRESSED/LONG), *_DEF parameter defaults.
package btn_pkg;
  typedef enum logic [1:0] {RELEASED, PRESSED, LONG} btn_state_t;
  localparam int STABLE_TICKS_DEF = 2;
  localparam int LONG_SECS_DEF = 2;
  localparam int REPEAT_TICKS_DEF = 8;
endpackage

// File: rtl/tick_debouncer.sv
// tick_debouncer: 2-flop synchroniser plus tick-sampled stability counter for one button.
//   i_clk, i_rst_n   clock, async active-low reset
//   i_btn_in         raw button, asynchronous to i_clk
//   i_db_tick        debounce sample strobe
//   o_level          debounced level (registered)
//   o_rise, o_fall   one-cycle events, high in the cycle whose edge flips o_level
module tick_debouncer
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_in,
  input  logic i_db_tick,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  logic [1:0]    r_sync;
  logic [SW-1:0] r_stab;
  logic          r_level;
  logic [SW-1:0] w_stab_inc;
  logic          w_diff;
  logic          w_flip;
  assign w_stab_inc = r_stab + SW'(1);
  assign w_diff     = r_sync[1] ^ r_level;
  assign w_flip     = i_db_tick && w_diff && (w_stab_inc == SW'(STABLE_TICKS));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_stab  <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn_in};
      if (i_db_tick) r_stab <= (!w_diff || w_flip) ? '0 : w_stab_inc;
      if (w_flip) r_level <= ~r_level;
    end
  end
  // events are combinational so the top can register its pulses on the same edge that flips r_level
  assign o_level = r_level;
  assign o_rise  = w_flip && !r_level;
  assign o_fall  = w_flip && r_level;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces one push-button and emits press/release/long/repeat event pulses.
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_btn_in                         raw button, active-high, asynchronous
//   i_db_tick, i_sec_tick            one-cycle strobes from the clock divider
//   o_btn_level                      debounced level
//   o_press/o_release/o_long/o_repeat_pulse  one-cycle mutually exclusive events
//   o_held_long                      high while in long press
module button_conditioner
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int LONG_SECS    = LONG_SECS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_in,
  input  logic i_db_tick,
  input  logic i_sec_tick,
  output logic o_btn_level,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_pulse,
  output logic o_repeat_pulse,
  output logic o_held_long
);
  localparam int SECW = $clog2(LONG_SECS + 1);
  localparam int REPW = $clog2(REPEAT_TICKS + 1);
  btn_state_t  r_state;
  logic [SECW-1:0] r_sec;
  logic [REPW-1:0] r_rep;
  logic r_press, r_release, r_long, r_repeat, r_held;
  logic w_level, w_rise, w_fall;
  logic [SECW-1:0] w_sec_inc;
  logic [REPW-1:0] w_rep_inc;
  logic w_sec_done, w_rep_done;
  tick_debouncer #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_btn_in  (i_btn_in),
    .i_db_tick (i_db_tick),
    .o_level   (w_level),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );
  assign w_sec_inc  = r_sec + SECW'(1);
  assign w_rep_inc  = r_rep + REPW'(1);
  assign w_sec_done = w_sec_inc == SECW'(LONG_SECS);
  assign w_rep_done = w_rep_inc == REPW'(REPEAT_TICKS);
  // fall is tested first in every state so a release always wins over a coinciding tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= RELEASED;
      r_sec     <= '0;
      r_rep     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      case (r_state)
        RELEASED: if (w_rise) begin
          r_state <= PRESSED;
          r_press <= 1'b1;
          r_sec   <= '0;
        end
        PRESSED: if (w_fall) begin
          r_state   <= RELEASED;
          r_release <= 1'b1;
          r_sec     <= '0;
        end else if (i_sec_tick) begin
          if (w_sec_done) begin
            r_state <= LONG;
            r_long  <= 1'b1;
            r_held  <= 1'b1;
            r_sec   <= '0;
            r_rep   <= '0;
          end else r_sec <= w_sec_inc;
        end
        LONG: if (w_fall) begin
          r_state   <= RELEASED;
          r_release <= 1'b1;
          r_held    <= 1'b0;
          r_sec     <= '0;
          r_rep     <= '0;
        end else if (i_db_tick) begin
          r_repeat <= w_rep_done;
          r_rep    <= w_rep_done ? '0 : w_rep_inc;
        end
        default: r_state <= RELEASED;
      endcase
    end
  end
  assign o_btn_level     = w_level;
  assign o_press_pulse   = r_press;
  assign o_release_pulse = r_release;
  assign o_long_pulse    = r_long;
  assign o_repeat_pulse  = r_repeat;
  assign o_held_long     = r_held;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with a pulse scoreboard for button_conditioner.
module tb_button_conditioner;
  localparam logic [3:0] P_PRESS = 4'b1000, P_REL = 4'b0100, P_LONG = 4'b0010, P_REP = 4'b0001;
  typedef struct {int e; logic [3:0] p;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, btn_in = 1'b0, db_tick = 1'b0, sec_tick = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, held_long;
  int edge_cnt = 0, sec_off = 5, total = 0, bad = 0;
  exp_t q[$];
  button_conditioner #(.STABLE_TICKS(2), .LONG_SECS(2), .REPEAT_TICKS(3)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_btn_in        (btn_in),
    .i_db_tick       (db_tick),
    .i_sec_tick      (sec_tick),
    .o_btn_level     (btn_level),
    .o_press_pulse   (press_pulse),
    .o_release_pulse (release_pulse),
    .o_long_pulse    (long_pulse),
    .o_repeat_pulse  (repeat_pulse),
    .o_held_long     (held_long)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  // ticks are set up on the negedge for the following posedge number edge_cnt+1
  initial forever begin
    @(negedge clk);
    db_tick  = ((edge_cnt + 1) % 10) == 0;
    sec_tick = ((edge_cnt + 1) % 100) == sec_off;
  end
  initial forever begin
    @(negedge clk);
    if ({press_pulse, release_pulse, long_pulse, repeat_pulse} != 4'b0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pulse: unexpected pulses=%b at edge %0d", {press_pulse, release_pulse, long_pulse, repeat_pulse}, edge_cnt);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (x.e != edge_cnt || x.p != {press_pulse, release_pulse, long_pulse, repeat_pulse}) begin
          bad++;
          $display("FAIL pulse: got %b at edge %0d, want %b at edge %0d", {press_pulse, release_pulse, long_pulse, repeat_pulse}, edge_cnt, x.p, x.e);
        end
      end
    end
  end
  task automatic at_edge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask
  task automatic drive_at(input int n, input logic v);
    at_edge(n - 1);
    btn_in = v;
  endtask
  task automatic expect_pulse(input int e, input logic [3:0] p);
    q.push_back('{e, p});
  endtask
  task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at edge %0d", nm, got, want, edge_cnt);
    end
  endtask
  function automatic logic [5:0] outs();
    return {btn_level, held_long, press_pulse, release_pulse, long_pulse, repeat_pulse};
  endfunction
  initial begin
    at_edge(1);
    chk("reset_outputs", outs(), 6'b0);
    at_edge(2);
    rst_n = 1'b1;
    expect_pulse(120, P_PRESS);
    expect_pulse(305, P_LONG);
    expect_pulse(330, P_REP);
    expect_pulse(360, P_REP);
    expect_pulse(390, P_REP);
    expect_pulse(420, P_REP);
    expect_pulse(450, P_REL);
    drive_at(101, 1'b1);
    at_edge(115);
    chk("level_before_press", {btn_level, held_long}, 6'b00);
    at_edge(125);
    chk("level_after_press", {btn_level, held_long}, 6'b10);
    at_edge(300);
    chk("held_before_long", {btn_level, held_long}, 6'b10);
    at_edge(310);
    chk("held_in_long", {btn_level, held_long}, 6'b11);
    drive_at(431, 1'b0);
    at_edge(445);
    chk("still_long_mid_fall", {btn_level, held_long}, 6'b11);
    at_edge(455);
    chk("released_from_long", {btn_level, held_long}, 6'b00);
    drive_at(495, 1'b1);
    drive_at(505, 1'b0);
    drive_at(515, 1'b1);
    drive_at(525, 1'b0);
    at_edge(545);
    chk("bounce_level", {btn_level, held_long}, 6'b00);
    at_edge(560);
    sec_off = 0;
    expect_pulse(600, P_PRESS);
    expect_pulse(800, P_REL);
    drive_at(581, 1'b1);
    at_edge(750);
    chk("press_with_sec_tick", {btn_level, held_long}, 6'b10);
    drive_at(781, 1'b0);
    at_edge(805);
    chk("release_beats_long", {btn_level, held_long}, 6'b00);
    expect_pulse(920, P_PRESS);
    expect_pulse(1100, P_LONG);
    expect_pulse(1130, P_REP);
    expect_pulse(1160, P_REP);
    expect_pulse(1200, P_PRESS);
    drive_at(901, 1'b1);
    at_edge(1165);
    chk("long_before_reset", {btn_level, held_long}, 6'b11);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", outs(), 6'b0);
    at_edge(1180);
    rst_n = 1'b1;
    at_edge(1195);
    chk("level_after_reset", {btn_level, held_long}, 6'b00);
    at_edge(1230);
    chk("repress_after_reset", {btn_level, held_long}, 6'b10);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses: got %0d outstanding want 0, next edge %0d", q.size(), q[0].e);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
